// File: rtl/ysyx_22041207_mem_arbiter.sv
// Arbitrates the single NPC memory port between IFU fetches and LSU loads/stores.
// One transaction is in flight at a time: IDLE -> ISSUE -> WAIT -> RESP, with an optional WAIT timeout.
module ysyx_22041207_mem_arbiter #(
   parameter int ADDR_W         = 64,
   parameter int DATA_W         = 64,
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              ifu_req_valid,
   output logic              ifu_req_ready,
   input  logic [ADDR_W-1:0] ifu_addr,
   output logic              ifu_resp_valid,
   output logic [31:0]       ifu_rdata,
   output logic              ifu_err,
   input  logic              lsu_req_valid,
   output logic              lsu_req_ready,
   input  logic [ADDR_W-1:0] lsu_addr,
   input  logic              lsu_wen,
   input  logic [7:0]        lsu_wmask,
   input  logic [DATA_W-1:0] lsu_wdata,
   output logic              lsu_resp_valid,
   output logic [DATA_W-1:0] lsu_rdata,
   output logic              lsu_err,
   output logic              mem_req_valid,
   input  logic              mem_req_ready,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_wen,
   output logic [7:0]        mem_wmask,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic              mem_resp_valid,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              busy
);

   localparam int CNT_W = (TIMEOUT_CYCLES < 1) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT_CYCLES < 1) ? 0 : TIMEOUT_CYCLES - 1);
   localparam logic TIMEOUT_EN = (TIMEOUT_CYCLES != 0);

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

   state_t           state;
   logic             owner_lsu;
   logic             last_lsu;
   logic [CNT_W-1:0] cnt;
   logic             grant_ifu;
   logic             grant_lsu;
   logic             lsu_eff_wen;
   logic             timeout_now;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (&v) ? v : v + CNT_W'(1);
   endfunction

   function automatic logic [31:0] fetch_word(input logic sel_hi, input logic [DATA_W-1:0] d);
      return sel_hi ? d[63:32] : d[31:0];
   endfunction

   // On a tie the requester that was not granted last time wins, so neither side starves.
   always_comb begin
      grant_lsu   = (state == IDLE) && lsu_req_valid && (!ifu_req_valid || !last_lsu);
      grant_ifu   = (state == IDLE) && ifu_req_valid && !grant_lsu;
      lsu_eff_wen = lsu_wen && (|lsu_wmask);
      timeout_now = TIMEOUT_EN && !mem_resp_valid && (cnt == CNT_LAST);
   end

   assign ifu_req_ready = grant_ifu;
   assign lsu_req_ready = grant_lsu;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state          <= IDLE;
         owner_lsu      <= 1'b0;
         last_lsu       <= 1'b0;
         cnt            <= '0;
         busy           <= 1'b0;
         mem_req_valid  <= 1'b0;
         mem_addr       <= '0;
         mem_wen        <= 1'b0;
         mem_wmask      <= '0;
         mem_wdata      <= '0;
         ifu_resp_valid <= 1'b0;
         ifu_rdata      <= '0;
         ifu_err        <= 1'b0;
         lsu_resp_valid <= 1'b0;
         lsu_rdata      <= '0;
         lsu_err        <= 1'b0;
      end else begin
         ifu_resp_valid <= 1'b0;
         ifu_rdata      <= '0;
         ifu_err        <= 1'b0;
         lsu_resp_valid <= 1'b0;
         lsu_rdata      <= '0;
         lsu_err        <= 1'b0;
         case (state)
            IDLE: begin
               if (grant_ifu || grant_lsu) begin
                  state         <= ISSUE;
                  busy          <= 1'b1;
                  mem_req_valid <= 1'b1;
                  owner_lsu     <= grant_lsu;
                  last_lsu      <= grant_lsu;
                  if (grant_lsu) begin
                     mem_addr  <= lsu_addr;
                     mem_wen   <= lsu_eff_wen;
                     mem_wmask <= lsu_eff_wen ? lsu_wmask : 8'h00;
                     mem_wdata <= lsu_wdata;
                  end else begin
                     mem_addr  <= ifu_addr;
                     mem_wen   <= 1'b0;
                     mem_wmask <= 8'h00;
                     mem_wdata <= '0;
                  end
               end
            end
            ISSUE: begin
               if (mem_req_ready) begin
                  mem_req_valid <= 1'b0;
                  cnt           <= '0;
                  state         <= WAIT;
               end
            end
            WAIT: begin
               cnt <= sat_inc(cnt);
               // A response landing on the timeout cycle still counts as a success.
               if (mem_resp_valid || timeout_now) begin
                  state <= RESP;
                  if (owner_lsu) begin
                     lsu_resp_valid <= 1'b1;
                     lsu_err        <= !mem_resp_valid;
                     lsu_rdata      <= (mem_resp_valid && !mem_wen) ? mem_rdata : '0;
                  end else begin
                     ifu_resp_valid <= 1'b1;
                     ifu_err        <= !mem_resp_valid;
                     ifu_rdata      <= mem_resp_valid ? fetch_word(mem_addr[2], mem_rdata) : 32'h0;
                  end
               end
            end
            RESP: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_ysyx_22041207_mem_arbiter.sv
// Scoreboard bench for the IFU/LSU memory arbiter with a small behavioural memory model.
module tb_ysyx_22041207_mem_arbiter;

   localparam int AW = 64;
   localparam int DW = 64;
   localparam int TO = 4;

   logic          clk = 1'b0;
   logic          rst;
   logic          ifu_req_valid, ifu_req_ready, ifu_resp_valid, ifu_err;
   logic [AW-1:0] ifu_addr;
   logic [31:0]   ifu_rdata;
   logic          lsu_req_valid, lsu_req_ready, lsu_wen, lsu_resp_valid, lsu_err;
   logic [AW-1:0] lsu_addr;
   logic [7:0]    lsu_wmask;
   logic [DW-1:0] lsu_wdata, lsu_rdata;
   logic          mem_req_valid, mem_req_ready, mem_wen, mem_resp_valid, busy;
   logic [AW-1:0] mem_addr;
   logic [7:0]    mem_wmask;
   logic [DW-1:0] mem_wdata, mem_rdata;

   always #5 clk = ~clk;

   ysyx_22041207_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYCLES(TO)) dut (
      .clk(clk), .rst(rst),
      .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready), .ifu_addr(ifu_addr),
      .ifu_resp_valid(ifu_resp_valid), .ifu_rdata(ifu_rdata), .ifu_err(ifu_err),
      .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready), .lsu_addr(lsu_addr),
      .lsu_wen(lsu_wen), .lsu_wmask(lsu_wmask), .lsu_wdata(lsu_wdata),
      .lsu_resp_valid(lsu_resp_valid), .lsu_rdata(lsu_rdata), .lsu_err(lsu_err),
      .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_addr(mem_addr),
      .mem_wen(mem_wen), .mem_wmask(mem_wmask), .mem_wdata(mem_wdata),
      .mem_resp_valid(mem_resp_valid), .mem_rdata(mem_rdata), .busy(busy)
   );

   typedef struct {
      bit          is_lsu;
      bit          err;
      logic [63:0] rdata;
      int          acc;
      int          tot;
   } resp_t;

   typedef struct {
      logic [63:0] addr;
      bit          wen;
      logic [7:0]  wmask;
      logic [63:0] wdata;
   } iss_t;

   resp_t       sb[$];
   iss_t        iq[$];
   int          n_cmp = 0;
   int          n_fail = 0;
   int          cyc = 0;
   int          ready_delay = 0;
   int          resp_delay = 1;
   logic [63:0] cfg_rdata = 64'h00100073_00000013;
   int          acc_ifu = 0;
   int          acc_lsu = 0;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
      end
   endfunction

   // Memory model: ready after ready_delay cycles, response resp_delay cycles after acceptance.
   initial begin : mem_model
      bit   pending;
      bit   seen;
      int   rdy_wait;
      int   wait_cnt;
      iss_t cur;
      iss_t ex;
      pending = 0; seen = 0; rdy_wait = 0; wait_cnt = 0;
      mem_req_ready = 1'b0;
      mem_resp_valid = 1'b0;
      mem_rdata = 64'h5A5A5A5A_5A5A5A5A;
      forever begin
         @(negedge clk);
         mem_resp_valid = 1'b0;
         mem_rdata = 64'h5A5A5A5A_5A5A5A5A;
         mem_req_ready = 1'b0;
         if (rst) begin
            pending = 0;
            seen = 0;
         end else begin
            if (pending) begin
               wait_cnt++;
               if (resp_delay > 0 && wait_cnt == resp_delay) begin
                  mem_resp_valid = 1'b1;
                  mem_rdata = cfg_rdata;
                  pending = 0;
               end
            end
            if (mem_req_valid) begin
               if (!seen) begin
                  seen = 1;
                  rdy_wait = 0;
                  cur.addr = mem_addr; cur.wen = mem_wen; cur.wmask = mem_wmask; cur.wdata = mem_wdata;
                  if (iq.size() == 0) begin
                     n_cmp++; n_fail++;
                     $display("FAIL unexpected_mem_req: addr %h with no request outstanding", mem_addr);
                  end else begin
                     ex = iq.pop_front();
                     chk("mem_addr", mem_addr, ex.addr);
                     chk("mem_wen", 64'(mem_wen), 64'(ex.wen));
                     chk("mem_wmask", 64'(mem_wmask), 64'(ex.wmask));
                     if (ex.wen) chk("mem_wdata", mem_wdata, ex.wdata);
                  end
               end else begin
                  chk("mem_addr_stable", mem_addr, cur.addr);
                  chk("mem_ctl_stable", 64'({mem_wen, mem_wmask}), 64'({cur.wen, cur.wmask}));
                  chk("mem_wdata_stable", mem_wdata, cur.wdata);
               end
               if (rdy_wait >= ready_delay) begin
                  mem_req_ready = 1'b1;
                  pending = 1;
                  wait_cnt = 0;
                  seen = 0;
               end else begin
                  rdy_wait++;
               end
            end
         end
      end
   end

   initial begin : monitor
      resp_t e;
      forever begin
         @(negedge clk);
         if (!rst && (ifu_resp_valid || lsu_resp_valid)) begin
            if (sb.size() == 0) begin
               n_cmp++; n_fail++;
               $display("FAIL unexpected_resp: ifu_v=%b lsu_v=%b with nothing outstanding", ifu_resp_valid, lsu_resp_valid);
            end else begin
               e = sb.pop_front();
               chk("resp_owner", 64'({ifu_resp_valid, lsu_resp_valid}), e.is_lsu ? 64'd1 : 64'd2);
               if (e.is_lsu) begin
                  chk("lsu_err", 64'(lsu_err), 64'(e.err));
                  chk("lsu_rdata", lsu_rdata, e.rdata);
                  chk("ifu_quiet", 64'({ifu_err, ifu_rdata}), 64'd0);
               end else begin
                  chk("ifu_err", 64'(ifu_err), 64'(e.err));
                  chk("ifu_rdata", 64'(ifu_rdata), e.rdata);
                  chk("lsu_quiet", lsu_rdata | 64'(lsu_err), 64'd0);
               end
               if (e.tot >= 0) chk("resp_latency", 64'(cyc - e.acc), 64'(e.tot));
            end
         end
      end
   end

   task automatic req(input bit is_lsu, input logic [63:0] addr, input bit wen, input logic [7:0] wmask,
                      input logic [63:0] wdata, input bit exp_wen, input logic [7:0] exp_wmask,
                      input bit push_resp, input bit exp_err, input logic [63:0] exp_rdata, input int tot);
      bit    got;
      iss_t  is;
      resp_t rs;
      got = 0;
      if (is_lsu) begin
         lsu_req_valid = 1'b1; lsu_addr = addr; lsu_wen = wen; lsu_wmask = wmask; lsu_wdata = wdata;
      end else begin
         ifu_req_valid = 1'b1; ifu_addr = addr;
      end
      for (int i = 0; i < 100 && !got; i++) begin
         #1;
         if (is_lsu ? lsu_req_ready : ifu_req_ready) begin
            got = 1;
            if (is_lsu) acc_lsu = cyc + 1; else acc_ifu = cyc + 1;
            is.addr = addr; is.wen = exp_wen; is.wmask = exp_wmask; is.wdata = wdata;
            iq.push_back(is);
            if (push_resp) begin
               rs.is_lsu = is_lsu; rs.err = exp_err; rs.rdata = exp_rdata; rs.acc = cyc + 1; rs.tot = tot;
               sb.push_back(rs);
            end
         end
         @(negedge clk);
      end
      if (is_lsu) lsu_req_valid = 1'b0; else ifu_req_valid = 1'b0;
      if (!got) begin
         n_cmp++; n_fail++;
         $display("FAIL req_accept_timeout: lsu=%0b addr %h never accepted", is_lsu, addr);
      end
   endtask

   task automatic wait_idle();
      int i;
      i = 0;
      @(negedge clk);
      while ((busy || sb.size() != 0) && i < 200) begin
         @(negedge clk);
         i++;
      end
      if (i >= 200) begin
         n_cmp++; n_fail++;
         $display("FAIL wait_idle_timeout: busy=%b outstanding=%0d", busy, sb.size());
      end
   endtask

   task automatic tie(input int k, input bit exp_lsu_first);
      logic [63:0] ia;
      logic [63:0] la;
      logic [63:0] iw;
      ia = 64'h8000_0000 + 64'(k * 4);
      la = 64'h8000_2000 + 64'(k * 8);
      iw = ia[2] ? 64'h00100073 : 64'h00000013;
      ifu_req_valid = 1'b1; ifu_addr = ia;
      lsu_req_valid = 1'b1; lsu_addr = la; lsu_wen = 1'b0; lsu_wmask = 8'h00;
      #1;
      chk("tie_grant", 64'({ifu_req_ready, lsu_req_ready}), exp_lsu_first ? 64'd1 : 64'd2);
      fork
         req(1'b1, la, 1'b0, 8'h00, 64'h0, 1'b0, 8'h00, 1'b1, 1'b0, cfg_rdata, 2);
         req(1'b0, ia, 1'b0, 8'h00, 64'h0, 1'b0, 8'h00, 1'b1, 1'b0, iw, 2);
      join
      if (exp_lsu_first) chk("tie_second_grant_gap", 64'(acc_ifu - acc_lsu), 64'd4);
      else               chk("tie_second_grant_gap", 64'(acc_lsu - acc_ifu), 64'd4);
      wait_idle();
   endtask

   initial begin : watchdog
      #2000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin : stim
      int rel;
      rst = 1'b1;
      ifu_req_valid = 1'b0; ifu_addr = '0;
      lsu_req_valid = 1'b0; lsu_addr = '0; lsu_wen = 1'b0; lsu_wmask = '0; lsu_wdata = '0;
      repeat (3) @(negedge clk);
      chk("rst_mem_req_valid", 64'(mem_req_valid), 64'd0);
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_resp_valids", 64'({ifu_resp_valid, lsu_resp_valid}), 64'd0);
      chk("rst_errs", 64'({ifu_err, lsu_err}), 64'd0);
      chk("rst_ifu_rdata", 64'(ifu_rdata), 64'd0);
      chk("rst_lsu_rdata", lsu_rdata, 64'd0);
      chk("rst_mem_fields", mem_addr | mem_wdata | 64'({mem_wen, mem_wmask}), 64'd0);
      chk("idle_readies_no_req", 64'({ifu_req_ready, lsu_req_ready}), 64'd0);
      rst = 1'b0;
      @(negedge clk);

      // IFU-only fetches, upper and lower word
      req(1'b0, 64'h8000_0004, 1'b0, 8'h00, 64'h0, 1'b0, 8'h00, 1'b1, 1'b0, 64'h00100073, 2);
      wait_idle();
      req(1'b0, 64'h8000_0000, 1'b0, 8'h00, 64'h0, 1'b0, 8'h00, 1'b1, 1'b0, 64'h00000013, 2);
      wait_idle();

      // Ties: last grant is IFU, so LSU wins every round
      for (int k = 0; k < 100; k++) tie(k, 1'b1);

      // After an LSU-only grant the IFU wins the next tie
      req(1'b1, 64'h8000_3000, 1'b0, 8'h00, 64'h0, 1'b0, 8'h00, 1'b1, 1'b0, cfg_rdata, 2);
      wait_idle();
      tie(5, 1'b0);

      // Store with delayed mem_req_ready
      ready_delay = 3;
      req(1'b1, 64'h8000_1000, 1'b1, 8'h0F, 64'h1122334455667788, 1'b1, 8'h0F, 1'b1, 1'b0, 64'h0, 5);
      wait_idle();
      ready_delay = 0;

      // wen=0 with a mask, and wen=1 with no mask, both issue as loads
      req(1'b1, 64'h8000_1008, 1'b0, 8'hFF, 64'hAAAA_BBBB_CCCC_DDDD, 1'b0, 8'h00, 1'b1, 1'b0, cfg_rdata, 2);
      wait_idle();
      req(1'b1, 64'h8000_1010, 1'b1, 8'h00, 64'hAAAA_BBBB_CCCC_DDDD, 1'b0, 8'h00, 1'b1, 1'b0, cfg_rdata, 2);
      wait_idle();

      // Timeouts, and a response on the last WAIT cycle
      resp_delay = -1;
      req(1'b1, 64'h8000_1018, 1'b0, 8'h00, 64'h0, 1'b0, 8'h00, 1'b1, 1'b1, 64'h0, 5);
      wait_idle();
      req(1'b0, 64'h8000_0010, 1'b0, 8'h00, 64'h0, 1'b0, 8'h00, 1'b1, 1'b1, 64'h0, 5);
      wait_idle();
      resp_delay = 4;
      cfg_rdata = 64'hDEADBEEF_CAFEF00D;
      req(1'b1, 64'h8000_1020, 1'b0, 8'h00, 64'h0, 1'b0, 8'h00, 1'b1, 1'b0, 64'hDEADBEEF_CAFEF00D, 5);
      wait_idle();
      cfg_rdata = 64'h00100073_00000013;

      // Asynchronous reset in WAIT drops the load; a held IFU request goes first after release
      resp_delay = -1;
      req(1'b1, 64'h8000_4000, 1'b0, 8'h00, 64'h0, 1'b0, 8'h00, 1'b0, 1'b0, 64'h0, -1);
      @(negedge clk);
      chk("busy_in_wait", 64'(busy), 64'd1);
      #2;
      rst = 1'b1;
      ifu_req_valid = 1'b1; ifu_addr = 64'h8000_0004;
      #1;
      chk("async_rst_busy", 64'(busy), 64'd0);
      chk("async_rst_outputs", 64'({mem_req_valid, ifu_resp_valid, lsu_resp_valid, ifu_err, lsu_err}), 64'd0);
      @(negedge clk);
      #2;
      resp_delay = 1;
      rst = 1'b0;
      rel = cyc;
      req(1'b0, 64'h8000_0004, 1'b0, 8'h00, 64'h0, 1'b0, 8'h00, 1'b1, 1'b0, 64'h00100073, 2);
      chk("accept_after_reset", 64'(acc_ifu), 64'(rel + 1));
      wait_idle();
      repeat (3) @(negedge clk);
      chk("scoreboard_drained", 64'(sb.size() + iq.size()), 64'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/ysyx_22041207_mem_arbiter.md
Name: ysyx_22041207_mem_arbiter

Overview:
- Shares the single NPC memory port between the instruction fetch unit (IFU) and the load/store unit (LSU).
- Each requester hands over one transaction through a valid/ready handshake. The block drives it onto the memory port, waits for the response (or a timeout), and returns one response pulse to the owner.
- It sits between IFU/LSU and the DPI-backed memory model. The LSU side is driven from the decoder's memoryReadWen/memoryWriteMask outputs.

Parameters:
- ADDR_W, 64, address width on all ports
- DATA_W, 64, memory data width
- TIMEOUT_CYCLES, 255, maximum cycles spent in WAIT before an error response; 0 disables the timeout

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous reset, active-high
- ifu_req_valid  in  1  IFU fetch request
- ifu_req_ready  out  1  IFU request accepted this cycle
- ifu_addr  in  ADDR_W  fetch address (4-byte aligned)
- ifu_resp_valid  out  1  one-cycle fetch response pulse
- ifu_rdata  out  32  fetched instruction
- ifu_err  out  1  fetch timed out (valid with ifu_resp_valid)
- lsu_req_valid  in  1  LSU request
- lsu_req_ready  out  1  LSU request accepted this cycle
- lsu_addr  in  ADDR_W  load/store address
- lsu_wen  in  1  1 = store, 0 = load
- lsu_wmask  in  8  byte write mask (decoder memoryWriteMask encoding)
- lsu_wdata  in  DATA_W  store data
- lsu_resp_valid  out  1  one-cycle LSU response pulse
- lsu_rdata  out  DATA_W  load data; 0 for stores and errors
- lsu_err  out  1  LSU access timed out
- mem_req_valid  out  1  request to memory
- mem_req_ready  in  1  memory accepts request
- mem_addr  out  ADDR_W  latched address
- mem_wen  out  1  write enable
- mem_wmask  out  8  write byte mask
- mem_wdata  out  DATA_W  write data
- mem_resp_valid  in  1  memory response / write acknowledge
- mem_rdata  in  DATA_W  memory read data
- busy  out  1  state != IDLE

Behaviour:
- FSM states: IDLE, ISSUE, WAIT, RESP. Registers: state, owner (IFU/LSU), last_grant, latched request fields, timeout counter, response data.
- Reset (asynchronous, any state) forces:
  - state=IDLE, last_grant=IFU, counter=0;
  - all outputs 0, including mem_req_valid, both resp_valid/err pulses and rdata;
  - any in-flight transaction is dropped with no response.
- IDLE, readies: ifu_req_ready/lsu_req_ready are combinational and high only in IDLE, for the granted requester only.
- IDLE, grant rule:
  - only one valid: it wins;
  - both valid: the requester that is not last_grant wins. After reset last_grant=IFU, so the LSU wins the first tie.
- IDLE, handshake (valid & ready):
  - latch addr/wen/wmask/wdata, set owner and last_grant, go to ISSUE;
  - IFU requests latch wen=0, wmask=0;
  - effective mem_wen = lsu_wen & |lsu_wmask; with wmask=0 the request is treated as a load and mem_wmask is forced to 0.
- ISSUE: mem_req_valid=1 with the latched fields held stable until mem_req_ready, then go to WAIT with counter=0. A request is never withdrawn once mem_req_valid is asserted.
- WAIT:
  - counter increments every cycle;
  - mem_resp_valid: capture mem_rdata, err=0, go to RESP;
  - otherwise, if TIMEOUT_CYCLES != 0 and counter == TIMEOUT_CYCLES-1: err=1, data=0, go to RESP;
  - mem_resp_valid on the same cycle as the timeout: the response wins, err=0;
  - mem_resp_valid outside WAIT is ignored. Memory must respond no earlier than the cycle after acceptance.
- RESP: exactly one cycle.
  - The owner's resp_valid=1, and its err reflects the timeout.
  - IFU: ifu_rdata = addr[2] ? data[63:32] : data[31:0].
  - LSU: lsu_rdata = data for loads, 0 for stores.
  - The non-owner's resp_valid/err/rdata stay 0.
  - Next state: IDLE.
- Latency: accept (IDLE) -> ISSUE -> WAIT (>=1 cycle) -> RESP. Minimum 4 cycles per transaction with immediate ready and 1-cycle memory latency. A new request is accepted no earlier than the IDLE cycle following RESP.
- Requests arriving while busy: not accepted and not lost; the requester holds valid.
- Counter width: $clog2(TIMEOUT_CYCLES+1), minimum 1; saturates and never wraps.
- Outputs: all registered except the two req_ready signals.

Test Plan:
- IFU-only fetch: addr=0x80000004, mem_req_ready=1, mem_rdata=0x00100073_00000013 one cycle after ISSUE -> ifu_resp_valid pulses once in cycle 4 with ifu_rdata=0x00100073, ifu_err=0, lsu_resp_valid stays 0.
- Simultaneous requests after reset -> LSU granted first, IFU granted on the next IDLE. Then both again -> LSU wins, because last_grant alternates. No starvation over 100 alternating ties.
- LSU store: addr=0x80001000, wmask=0x0F, wdata=0x1122334455667788, mem_req_ready delayed 3 cycles -> mem_* fields stay stable and valid throughout; lsu_resp_valid pulses with lsu_rdata=0 after the ack.
- LSU load with wmask=0xFF but lsu_wen=0, then store with wen=1 and wmask=0 -> both issue mem_wen=0, mem_wmask=0.
- Timeout: TIMEOUT_CYCLES=4, memory never responds -> lsu_err=1 and lsu_rdata=0 exactly 4 cycles after entering WAIT, then IDLE. A response arriving on the 4th WAIT cycle gives err=0 with the data returned.
- rst asserted during WAIT -> outputs 0 immediately (asynchronous). After release, a pending IFU request is accepted in the first IDLE cycle and no stale response is delivered.
